// File: rtl/fsk_pkg.sv
// Shared encodings for the FSK tone sequencer: FSM states, command constants
// and the status-byte packing helper.
package fsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_LOCK  = 2'd2,
        ST_ON    = 2'd3
    } fsk_state_e;

    typedef enum logic {
        HAVE_NONE = 1'b0,
        HAVE_HI   = 1'b1
    } asm_state_e;

    localparam logic [15:0] CMD_DISABLE = 16'h0000;
    localparam logic [3:0]  ACK_TAG     = 4'hA;
    localparam logic        TONE_888    = 1'b0;
    localparam logic        TONE_936    = 1'b1;

    function automatic logic [7:0] status_byte(input logic fault,
                                               input logic tone,
                                               input logic on);
        return {ACK_TAG, 1'b0, fault, tone, on};
    endfunction

endpackage

// File: rtl/fsk_cmd_assembler.sv
// Pairs two UART bytes into a 16-bit command word; a lone first byte is
// dropped once the inter-byte timeout expires.
module fsk_cmd_assembler
    import fsk_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT = 48_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_strobe,
    output logic [15:0] cmd_word
);

    localparam int unsigned CW = $clog2(BYTE_TIMEOUT + 1);

    asm_state_e     state_q, state_d;
    logic [7:0]     rx_data_q;
    logic           rx_valid_q;
    logic [7:0]     hi_q, hi_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           strobe_q, strobe_d;
    logic [15:0]    word_q, word_d;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        word_d   = word_q;
        case (state_q)
            HAVE_NONE: begin
                if (rx_valid_q) begin
                    hi_d    = rx_data_q;
                    cnt_d   = CW'(BYTE_TIMEOUT - 1);
                    state_d = HAVE_HI;
                end
            end
            HAVE_HI: begin
                // A second byte arriving on the last timeout cycle still completes the word.
                if (rx_valid_q) begin
                    word_d   = {hi_q, rx_data_q};
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = HAVE_NONE;
                end else if (cnt_q == '0) begin
                    state_d = HAVE_NONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = HAVE_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HAVE_NONE;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            hi_q       <= '0;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            rx_data_q  <= rx_data;
            rx_valid_q <= rx_valid;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            strobe_q   <= strobe_d;
            word_q     <= word_d;
        end
    end

    assign cmd_strobe = strobe_q;
    assign cmd_word   = word_q;

endmodule

// File: rtl/fsk_tone_sequencer.sv
// Sequences the 888/936 MHz tone oscillators from 2-byte UART commands with
// break-before-make guard time, PLL-lock gating and a status-byte return path.
//
// state | meaning
// IDLE  | both enables low, waiting for a command
// GUARD | both enables low, guard counter running
// LOCK  | both enables low, waiting for the target PLL lock
// ON    | selected tone enabled
module fsk_tone_sequencer
    import fsk_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 48_000_000,
    parameter int unsigned BYTE_TIMEOUT = CLK_HZ / 1_000,
    parameter int unsigned GUARD_CYCLES = CLK_HZ / 1_000_000,
    parameter int unsigned LOCK_TIMEOUT = CLK_HZ / 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       lock_888,
    input  logic       lock_936,
    output logic       en_888,
    output logic       en_936,
    output logic       wave_active,
    output logic       busy,
    output logic [7:0] ack_data,
    output logic       ack_valid,
    input  logic       ack_ready
);

    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);

    logic        cmd_strobe;
    logic [15:0] cmd_word;

    fsk_cmd_assembler #(
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_strobe (cmd_strobe),
        .cmd_word   (cmd_word)
    );

    fsk_state_e     state_q, state_d;
    logic           tone_q, tone_d;
    logic           fault_q, fault_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic [LW-1:0]  lockc_q, lockc_d;
    logic           emit;
    logic [7:0]     status_d;
    logic           tgt_lock;
    logic           en_888_q, en_936_q, busy_q, ack_valid_q;
    logic [7:0]     ack_data_q;

    assign tgt_lock = (tone_q == TONE_936) ? lock_936 : lock_888;

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        fault_d = fault_q;
        guard_d = guard_q;
        lockc_d = lockc_q;
        emit    = 1'b0;
        if (cmd_strobe) begin
            fault_d = 1'b0;
            tone_d  = cmd_word[0];
            if (cmd_word == CMD_DISABLE) begin
                state_d = ST_IDLE;
                emit    = 1'b1;
            end else if (state_q == ST_ON && cmd_word[0] == tone_q) begin
                emit = 1'b1;
            end else begin
                state_d = ST_GUARD;
                guard_d = GW'(GUARD_CYCLES - 1);
                lockc_d = '0;
            end
        end else begin
            case (state_q)
                ST_GUARD: begin
                    if (guard_q == '0) begin
                        state_d = ST_LOCK;
                        lockc_d = LW'(LOCK_TIMEOUT - 1);
                    end else begin
                        guard_d = guard_q - GW'(1);
                    end
                end
                ST_LOCK: begin
                    if (tgt_lock) begin
                        state_d = ST_ON;
                        emit    = 1'b1;
                    end else if (lockc_q == '0) begin
                        state_d = ST_IDLE;
                        fault_d = 1'b1;
                        emit    = 1'b1;
                    end else begin
                        lockc_d = lockc_q - LW'(1);
                    end
                end
                ST_ON: begin
                    if (!tgt_lock) begin
                        state_d = ST_IDLE;
                        fault_d = 1'b1;
                        emit    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        status_d = status_byte(fault_d, tone_d, state_d == ST_ON);
    end

    // Enables are decoded from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tone_q      <= TONE_888;
            fault_q     <= 1'b0;
            guard_q     <= '0;
            lockc_q     <= '0;
            en_888_q    <= 1'b0;
            en_936_q    <= 1'b0;
            busy_q      <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_data_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            tone_q   <= tone_d;
            fault_q  <= fault_d;
            guard_q  <= guard_d;
            lockc_q  <= lockc_d;
            en_888_q <= (state_d == ST_ON) && (tone_d == TONE_888);
            en_936_q <= (state_d == ST_ON) && (tone_d == TONE_936);
            busy_q   <= (state_d == ST_GUARD) || (state_d == ST_LOCK);
            if (emit) begin
                ack_valid_q <= 1'b1;
                ack_data_q  <= status_d;
            end else if (ack_ready) begin
                ack_valid_q <= 1'b0;
            end
        end
    end

    assign en_888      = en_888_q;
    assign en_936      = en_936_q;
    assign wave_active = en_888_q | en_936_q;
    assign busy        = busy_q;
    assign ack_valid   = ack_valid_q;
    assign ack_data    = ack_data_q;

endmodule

// File: tb/tb_fsk_tone_sequencer.sv
// Self-checking bench for fsk_tone_sequencer: cycle-accurate enable checks
// plus a scoreboard of expected status bytes popped on each ack handshake.
module tb_fsk_tone_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       lock_888, lock_936;
    logic       en_888, en_936, wave_active, busy;
    logic [7:0] ack_data;
    logic       ack_valid;
    logic       ack_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fsk_tone_sequencer #(
        .CLK_HZ       (48_000_000),
        .BYTE_TIMEOUT (100),
        .GUARD_CYCLES (4),
        .LOCK_TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .lock_888    (lock_888),
        .lock_936    (lock_936),
        .en_888      (en_888),
        .en_936      (en_936),
        .wave_active (wave_active),
        .busy        (busy),
        .ack_data    (ack_data),
        .ack_valid   (ack_valid),
        .ack_ready   (ack_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Returns one time unit after C0, the edge sampling the second byte.
    task automatic send_cmd(input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b1);
        send_byte(b2);
    endtask

    initial begin : ack_monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (ack_valid && ack_ready && !rst) begin
                chk("ack_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ack_data_sb", ack_data, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        lock_888 = 1'b1; lock_936 = 1'b1; ack_ready = 1'b1;
        step(3);
        chk("rst_en", {en_888, en_936, wave_active, busy}, 0);
        chk("rst_ack", {ack_valid, ack_data}, 0);
        rst = 1'b0;
        step(2);

        // 888 MHz from idle
        exp_q.push_back(8'hA1);
        send_cmd(8'hFF, 8'h00);
        step(1);
        chk("t1_c1_busy", busy, 0);
        step(1);
        chk("t1_c2_busy", busy, 1);
        chk("t1_c2_en", {en_888, en_936}, 0);
        step(4);
        chk("t1_c6_en888", en_888, 0);
        chk("t1_c6_busy", busy, 1);
        step(1);
        chk("t1_c7_en", {en_888, en_936}, 2'b10);
        chk("t1_c7_wave", wave_active, 1);
        chk("t1_c7_ackv", ack_valid, 1);
        chk("t1_c7_ackd", ack_data, 8'hA1);
        step(3);

        // switch to 936 MHz with break-before-make
        exp_q.push_back(8'hA3);
        send_cmd(8'hFF, 8'h01);
        step(1);
        chk("t2_c1_en888", en_888, 1);
        for (int k = 2; k <= 6; k++) begin
            step(1);
            chk("t2_gap", {en_888, en_936}, 0);
        end
        step(1);
        chk("t2_c7_en", {en_888, en_936}, 2'b01);
        step(3);

        // same-tone no-op
        exp_q.push_back(8'hA3);
        send_cmd(8'hFF, 8'h01);
        step(1);
        chk("t3_c1_en936", en_936, 1);
        step(1);
        chk("t3_c2_en936", en_936, 1);
        chk("t3_c2_ackv", ack_valid, 1);
        chk("t3_c2_ackd", ack_data, 8'hA3);
        chk("t3_c2_busy", busy, 0);
        step(1);
        chk("t3_c3_en936", en_936, 1);
        step(3);

        // disable
        exp_q.push_back(8'hA0);
        send_cmd(8'h00, 8'h00);
        step(1);
        chk("t4_c1_en936", en_936, 1);
        step(1);
        chk("t4_c2_en", {en_888, en_936}, 0);
        chk("t4_c2_ackv", ack_valid, 1);
        chk("t4_c2_ackd", ack_data, 8'hA0);
        step(3);

        // lock timeout on 888
        lock_888 = 1'b0;
        exp_q.push_back(8'hA4);
        send_cmd(8'hFF, 8'h00);
        step(7);
        chk("t5_c7_en888", en_888, 0);
        chk("t5_c7_busy", busy, 1);
        step(48);
        chk("t5_c55_busy", busy, 1);
        chk("t5_c55_ackv", ack_valid, 0);
        step(1);
        chk("t5_c56_busy", busy, 0);
        chk("t5_c56_ackv", ack_valid, 1);
        chk("t5_c56_ackd", ack_data, 8'hA4);
        chk("t5_c56_en888", en_888, 0);
        lock_888 = 1'b1;
        step(3);

        // orphan byte discarded by inter-byte timeout
        send_byte(8'hFF);
        step(101);
        chk("t6_orphan_ackv", ack_valid, 0);
        exp_q.push_back(8'hA3);
        send_cmd(8'h00, 8'h01);
        step(7);
        chk("t6_c7_en", {en_888, en_936}, 2'b01);
        step(3);

        // ack overwrite while TX is stalled
        ack_ready = 1'b0;
        send_cmd(8'h00, 8'h00);
        step(2);
        chk("t7_first_ackd", ack_data, 8'hA0);
        step(3);
        exp_q.push_back(8'hA1);
        send_cmd(8'hFF, 8'h00);
        step(7);
        chk("t7_c7_ackv", ack_valid, 1);
        chk("t7_c7_ackd", ack_data, 8'hA1);
        chk("t7_c7_en888", en_888, 1);
        step(5);
        chk("t7_hold_ackv", ack_valid, 1);
        chk("t7_hold_ackd", ack_data, 8'hA1);
        ack_ready = 1'b1;
        step(2);
        chk("t7_drained", ack_valid, 0);
        step(2);

        // reset in the middle of GUARD
        send_cmd(8'hFF, 8'h01);
        step(3);
        chk("t8_c3_busy", busy, 1);
        rst = 1'b1;
        step(1);
        chk("t8_rst_en", {en_888, en_936, wave_active, busy}, 0);
        chk("t8_rst_ack", {ack_valid, ack_data}, 0);
        rst = 1'b0;
        step(10);
        chk("t8_post_en", {en_888, en_936, busy}, 0);
        chk("t8_post_ackv", ack_valid, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
